exec_ctrl: RTL and testbench
============================

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waited in WAIT_INST/MEM_WAIT before bus-error trap.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports ifu_req_valid (output, 1) and ifu_req_ready (input, 1): fetch request handshake.
REQ-005 SHALL have ports ifu_rsp_valid (input, 1) and ifu_rsp_err (input, 1): instruction returned / fetch fault.
REQ-006 SHALL have port ir_we, output, 1: capture fetched word into instruction register.
REQ-007 SHALL have decoder inputs dec_mem_read, dec_mem_write, dec_reg_write, dec_branch, dec_jal, dec_jalr, dec_ecall, dec_ebreak, dec_csr, dec_illegal, each input, 1.
REQ-008 SHALL have port br_taken, input, 1: ALU branch compare result.
REQ-009 SHALL have ports lsu_req_valid (output, 1), lsu_req_we (output, 1), lsu_req_ready (input, 1): LSU request handshake.
REQ-010 SHALL have ports lsu_rsp_valid (input, 1) and lsu_rsp_err (input, 1): LSU completion / fault.
REQ-011 SHALL have outputs rf_we (1), csr_we (1), pc_we (1), mepc_we (1), pc_sel (2): 00 pc+4, 01 pc+imm, 10 rs1+imm, 11 mtvec.
REQ-012 SHALL have outputs trap_cause (2; 00 ecall, 01 illegal, 10 fetch fault/timeout, 11 load-store fault/timeout), halt (1), retire (1), instret (32).

Function
REQ-013 SHALL implement states FETCH, WAIT_INST, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, TRAP, HALT, one-hot or binary.
REQ-014 FETCH: ifu_req_valid=1; on ifu_req_ready -> WAIT_INST.
REQ-015 WAIT_INST: on ifu_rsp_valid & !ifu_rsp_err, pulse ir_we -> DECODE; on ifu_rsp_err -> TRAP, cause 10.
REQ-016 DECODE: one cycle; priority dec_ebreak -> HALT, dec_illegal -> TRAP (01), dec_ecall -> TRAP (00), else -> EXEC.
REQ-017 EXEC: one cycle; if dec_mem_read|dec_mem_write -> MEM_REQ, else -> WB.
REQ-018 MEM_REQ: lsu_req_valid=1, lsu_req_we=dec_mem_write, held stable until lsu_req_ready; then -> MEM_WAIT.
REQ-019 MEM_WAIT: on lsu_rsp_valid & !lsu_rsp_err -> WB; on lsu_rsp_err -> TRAP, cause 11; rf_we never asserted on fault.
REQ-020 WB: one cycle; rf_we=dec_reg_write, csr_we=dec_csr, pc_we=1, retire=1; -> FETCH.
REQ-021 WB pc_sel: 10 if dec_jalr; 01 if dec_jal or (dec_branch & br_taken); else 00.
REQ-022 TRAP: one cycle; mepc_we=1, pc_we=1, pc_sel=11, trap_cause valid; no retire; -> FETCH.
REQ-023 HALT: absorbing; halt=1; all request/write strobes 0; exit only by reset.
REQ-024 Wait counter SHALL clear on WAIT_INST/MEM_WAIT entry, increment per waiting cycle, and force TRAP (cause 10/11) when it equals TIMEOUT without response.
REQ-025 Response and timeout in the same cycle: response wins.
REQ-026 instret SHALL increment by 1 on each retire, wrapping 0xFFFFFFFF -> 0.
REQ-027 All strobes (ir_we, rf_we, csr_we, pc_we, mepc_we, retire) SHALL be single-cycle pulses, 0 outside their state.
REQ-028 Minimum latency: non-memory instruction 5 cycles FETCH-to-FETCH with 0-wait IFU; memory instruction 7.
REQ-029 trap_cause SHALL hold its last value outside TRAP.

Reset
REQ-030 On rst_n=0, state SHALL become FETCH asynchronously; all outputs 0, pc_sel 00, trap_cause 00, instret 0, wait counter 0.
REQ-031 Reset mid-transaction SHALL abandon any outstanding IFU/LSU request; ifu_req_valid SHALL assert in the first cycle after deassertion.

Structure
REQ-032 State encoding, pc_sel codes and trap_cause codes SHALL live in a shared package npc_ctrl_pkg.
REQ-033 Wait counter with timeout compare SHALL be sub-module wait_timer; all else in exec_ctrl.

Verification
REQ-034 ADDI, 0-wait IFU: retire at cycle 5 after reset release, pc_sel=00, rf_we=1, instret=1.
REQ-035 LW with lsu_req_ready delayed 3 cycles, rsp 2 cycles later: lsu_req_valid held 4 cycles, rf_we in WB, FETCH-to-FETCH 12 cycles.
REQ-036 BEQ br_taken=1 then BNE br_taken=0: pc_sel 01 then 00, rf_we=0 both.
REQ-037 SW with no lsu_rsp_valid, TIMEOUT=4: TRAP after 4 MEM_WAIT cycles, trap_cause=11, mepc_we=1, instret unchanged.
REQ-038 ECALL then EBREAK: TRAP with cause 00 and pc_sel 11; then HALT, halt=1 held 20 cycles, no ifu_req_valid.
REQ-039 rst_n low during MEM_WAIT: outputs 0 immediately, ifu_req_valid=1 first cycle after release, instret=0.

Source files
------------

// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared FSM state encoding, pc_sel codes and trap_cause codes
package npc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH,
    S_WAIT_INST,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_TRAP,
    S_HALT
  } state_t;
  localparam logic [1:0] PC_PLUS4      = 2'b00;
  localparam logic [1:0] PC_IMM        = 2'b01;
  localparam logic [1:0] PC_RS1        = 2'b10;
  localparam logic [1:0] PC_MTVEC      = 2'b11;
  localparam logic [1:0] CAUSE_ECALL   = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IFU     = 2'b10;
  localparam logic [1:0] CAUSE_LSU     = 2'b11;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts cycles while run is high (cleared otherwise); expired flags the TIMEOUT-th waiting cycle
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d   = run ? cnt_q + W'(1) : '0;
    expired = run && (cnt_q == W'(TIMEOUT - 1));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle fetch/decode/exec/mem/writeback sequencer with trap, halt and retire counting
module exec_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic        ifu_rsp_err,
  output logic        ir_we,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic        dec_reg_write,
  input  logic        dec_branch,
  input  logic        dec_jal,
  input  logic        dec_jalr,
  input  logic        dec_ecall,
  input  logic        dec_ebreak,
  input  logic        dec_csr,
  input  logic        dec_illegal,
  input  logic        br_taken,
  output logic        lsu_req_valid,
  output logic        lsu_req_we,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  input  logic        lsu_rsp_err,
  output logic        rf_we,
  output logic        csr_we,
  output logic        pc_we,
  output logic        mepc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  trap_cause,
  output logic        halt,
  output logic        retire,
  output logic [31:0] instret
);
  state_t      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;
  logic        expired;
  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state_q == S_WAIT_INST || state_q == S_MEM_WAIT),
    .expired (expired)
  );
  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    ifu_req_valid = 1'b0;
    ir_we         = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_we    = 1'b0;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    pc_we         = 1'b0;
    mepc_we       = 1'b0;
    pc_sel        = PC_PLUS4;
    halt          = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ifu_req_valid = rst_n;
        state_d       = ifu_req_ready ? S_WAIT_INST : S_FETCH;
      end
      S_WAIT_INST: begin
        if (ifu_rsp_valid && !ifu_rsp_err) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (ifu_rsp_err || expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IFU;
        end
      end
      S_DECODE: begin
        state_d = dec_ebreak  ? S_HALT :
                  dec_illegal ? S_TRAP :
                  dec_ecall   ? S_TRAP : S_EXEC;
        cause_d = dec_ebreak  ? cause_q :
                  dec_illegal ? CAUSE_ILLEGAL :
                  dec_ecall   ? CAUSE_ECALL : cause_q;
      end
      S_EXEC: state_d = (dec_mem_read || dec_mem_write) ? S_MEM_REQ : S_WB;
      S_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_we    = dec_mem_write;
        state_d       = lsu_req_ready ? S_MEM_WAIT : S_MEM_REQ;
      end
      S_MEM_WAIT: begin
        if (lsu_rsp_valid && !lsu_rsp_err) state_d = S_WB;
        else if (lsu_rsp_err || expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_LSU;
        end
      end
      S_WB: begin
        rf_we   = dec_reg_write;
        csr_we  = dec_csr;
        pc_we   = 1'b1;
        retire  = 1'b1;
        pc_sel  = dec_jalr ? PC_RS1 : (dec_jal || (dec_branch && br_taken)) ? PC_IMM : PC_PLUS4;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        mepc_we = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = PC_MTVEC;
        state_d = S_FETCH;
      end
      S_HALT:  halt = 1'b1;
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + {31'd0, retire};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cause_q   <= CAUSE_ECALL;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  assign trap_cause = cause_q;
  assign instret    = instret_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed scenario tests for exec_ctrl
module tb_exec_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ir_we;
  logic dec_mem_read, dec_mem_write, dec_reg_write, dec_branch, dec_jal, dec_jalr;
  logic dec_ecall, dec_ebreak, dec_csr, dec_illegal, br_taken;
  logic lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic rf_we, csr_we, pc_we, mepc_we, halt, retire;
  logic [1:0] pc_sel, trap_cause;
  logic [31:0] instret;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  exec_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ir_we(ir_we),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
    .dec_branch(dec_branch), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_ecall(dec_ecall),
    .dec_ebreak(dec_ebreak), .dec_csr(dec_csr), .dec_illegal(dec_illegal), .br_taken(br_taken),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err),
    .rf_we(rf_we), .csr_we(csr_we), .pc_we(pc_we), .mepc_we(mepc_we), .pc_sel(pc_sel),
    .trap_cause(trap_cause), .halt(halt), .retire(retire), .instret(instret)
  );
  task automatic apply_reset();
    rst_n = 1'b0;
    {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err} = '0;
    {dec_mem_read, dec_mem_write, dec_reg_write, dec_branch, dec_jal, dec_jalr} = '0;
    {dec_ecall, dec_ebreak, dec_csr, dec_illegal, br_taken} = '0;
    {lsu_req_ready, lsu_rsp_valid, lsu_rsp_err} = '0;
    repeat (2) @(posedge clk);
  endtask
  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    apply_reset();
    ifu_req_ready = 1'b1;
    @(negedge clk);
    total++; if (ifu_req_valid !== 1'b0) $display("FAIL reset_ifu_valid: got %b want 0", ifu_req_valid); else passed++;
    total++; if ({ir_we, lsu_req_valid, rf_we, csr_we, pc_we, mepc_we, halt, retire} !== 8'b0) $display("FAIL reset_strobes: got %b want 0", {ir_we, lsu_req_valid, rf_we, csr_we, pc_we, mepc_we, halt, retire}); else passed++;
    total++; if ({pc_sel, trap_cause} !== 4'b0) $display("FAIL reset_codes: got %b want 0000", {pc_sel, trap_cause}); else passed++;
    total++; if (instret !== 32'd0) $display("FAIL reset_instret: got %0d want 0", instret); else passed++;
    release_reset();
    @(negedge clk);
    total++; if (ifu_req_valid !== 1'b1) $display("FAIL reset_first_fetch: got %b want 1", ifu_req_valid); else passed++;
  endtask
  task automatic test_addi();
    int rc = 0, ic = 0;
    apply_reset();
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; dec_reg_write = 1'b1;
    release_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (retire && rc == 0) rc = c;
      if (ir_we && ic == 0) ic = c;
      if (c == 5) begin
        total++; if (rf_we !== 1'b1 || pc_we !== 1'b1) $display("FAIL addi_wb_strobes: got rf_we=%b pc_we=%b want 1 1", rf_we, pc_we); else passed++;
        total++; if (pc_sel !== 2'b00) $display("FAIL addi_pc_sel: got %b want 00", pc_sel); else passed++;
      end
      if (c == 6) begin
        total++; if (instret !== 32'd1) $display("FAIL addi_instret: got %0d want 1", instret); else passed++;
        total++; if (ifu_req_valid !== 1'b1 || retire !== 1'b0) $display("FAIL addi_refetch: got valid=%b retire=%b want 1 0", ifu_req_valid, retire); else passed++;
      end
      next_cycle();
    end
    total++; if (rc != 5) $display("FAIL addi_retire_cycle: got %0d want 5", rc); else passed++;
    total++; if (ic != 2) $display("FAIL addi_ir_we_cycle: got %0d want 2", ic); else passed++;
  endtask
  task automatic test_lw();
    int vc = 0, wc = 0, fc = 0, bad_we = 0;
    apply_reset();
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; dec_mem_read = 1'b1; dec_reg_write = 1'b1;
    release_reset();
    for (int c = 1; c <= 13; c++) begin
      lsu_req_ready = (c == 8);
      lsu_rsp_valid = (c == 11);
      @(negedge clk);
      if (lsu_req_valid) vc++;
      if (lsu_req_valid && lsu_req_we) bad_we++;
      if (rf_we && wc == 0) wc = c;
      if (c > 1 && ifu_req_valid && fc == 0) fc = c;
      next_cycle();
    end
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    total++; if (vc != 4) $display("FAIL lw_req_hold: got %0d cycles want 4", vc); else passed++;
    total++; if (bad_we != 0) $display("FAIL lw_req_we: got %0d cycles with we=1 want 0", bad_we); else passed++;
    total++; if (wc != 12) $display("FAIL lw_rf_we_cycle: got %0d want 12", wc); else passed++;
    total++; if (fc != 13) $display("FAIL lw_fetch_to_fetch: got next fetch at cycle %0d want 13", fc); else passed++;
  endtask
  task automatic test_branch_jump();
    logic [1:0] exp_sel [4] = '{2'b01, 2'b00, 2'b10, 2'b01};
    apply_reset();
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
    release_reset();
    for (int i = 0; i < 4; i++) begin
      dec_branch = (i < 2); br_taken = (i == 0); dec_jalr = (i == 2); dec_jal = (i == 3); dec_reg_write = (i >= 2);
      repeat (4) next_cycle();
      @(negedge clk);
      total++; if (retire !== 1'b1 || pc_sel !== exp_sel[i]) $display("FAIL br_pc_sel_%0d: got retire=%b pc_sel=%b want 1 %b", i, retire, pc_sel, exp_sel[i]); else passed++;
      total++; if (rf_we !== (i >= 2)) $display("FAIL br_rf_we_%0d: got %b want %b", i, rf_we, (i >= 2)); else passed++;
      next_cycle();
    end
    @(negedge clk);
    total++; if (instret !== 32'd4) $display("FAIL br_instret: got %0d want 4", instret); else passed++;
  endtask
  task automatic test_mem_timeout(input logic resp_late);
    int tc = 0, rc = 0;
    apply_reset();
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; dec_mem_write = 1'b1; dec_reg_write = resp_late; lsu_req_ready = 1'b1;
    release_reset();
    for (int c = 1; c <= 11; c++) begin
      lsu_rsp_valid = resp_late && (c == 9);
      @(negedge clk);
      if (c == 5) begin
        total++; if (lsu_req_valid !== 1'b1 || lsu_req_we !== 1'b1) $display("FAIL sw_req: got valid=%b we=%b want 1 1", lsu_req_valid, lsu_req_we); else passed++;
      end
      if (mepc_we && tc == 0) tc = c;
      if (retire && rc == 0) rc = c;
      if (c == 10 && !resp_late) begin
        total++; if (trap_cause !== 2'b11 || pc_sel !== 2'b11 || pc_we !== 1'b1 || rf_we !== 1'b0) $display("FAIL sw_trap_outputs: got cause=%b pc_sel=%b pc_we=%b rf_we=%b want 11 11 1 0", trap_cause, pc_sel, pc_we, rf_we); else passed++;
      end
      next_cycle();
    end
    lsu_rsp_valid = 1'b0;
    if (resp_late) begin
      total++; if (rc != 10 || tc != 0) $display("FAIL resp_wins: got retire at %0d trap at %0d want 10 and 0", rc, tc); else passed++;
    end else begin
      total++; if (tc != 10 || rc != 0) $display("FAIL sw_timeout: got trap at %0d retire at %0d want 10 and 0", tc, rc); else passed++;
      total++; if (instret !== 32'd0 || trap_cause !== 2'b11) $display("FAIL sw_after_trap: got instret=%0d cause=%b want 0 11", instret, trap_cause); else passed++;
    end
  endtask
  task automatic test_ifu_faults();
    int tc = 0;
    apply_reset();
    ifu_req_ready = 1'b1;
    release_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mepc_we && tc == 0) tc = c;
      next_cycle();
    end
    total++; if (tc != 6 || trap_cause !== 2'b10) $display("FAIL ifu_timeout: got trap at %0d cause=%b want 6 10", tc, trap_cause); else passed++;
    apply_reset();
    ifu_req_ready = 1'b1;
    release_reset();
    ifu_rsp_valid = 1'b0; tc = 0;
    for (int c = 1; c <= 3; c++) begin
      ifu_rsp_err = (c == 2); ifu_rsp_valid = (c == 2);
      @(negedge clk);
      if (c == 2) begin
        total++; if (ir_we !== 1'b0) $display("FAIL ifu_err_ir_we: got %b want 0", ir_we); else passed++;
      end
      if (mepc_we && tc == 0) tc = c;
      next_cycle();
    end
    total++; if (tc != 3 || trap_cause !== 2'b10) $display("FAIL ifu_err_trap: got trap at %0d cause=%b want 3 10", tc, trap_cause); else passed++;
  endtask
  task automatic test_ecall_ebreak();
    int bad = 0;
    apply_reset();
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; dec_illegal = 1'b1;
    release_reset();
    repeat (3) next_cycle();
    @(negedge clk);
    total++; if (mepc_we !== 1'b1 || trap_cause !== 2'b01 || retire !== 1'b0) $display("FAIL illegal_trap: got mepc_we=%b cause=%b retire=%b want 1 01 0", mepc_we, trap_cause, retire); else passed++;
    next_cycle();
    dec_illegal = 1'b0; dec_ecall = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    total++; if (mepc_we !== 1'b1 || trap_cause !== 2'b00 || pc_sel !== 2'b11) $display("FAIL ecall_trap: got mepc_we=%b cause=%b pc_sel=%b want 1 00 11", mepc_we, trap_cause, pc_sel); else passed++;
    next_cycle();
    dec_ebreak = 1'b1; dec_illegal = 1'b1;
    repeat (3) next_cycle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!halt || ifu_req_valid || pc_we || mepc_we || retire || lsu_req_valid) bad++;
      next_cycle();
    end
    total++; if (bad != 0) $display("FAIL halt_hold: got %0d bad cycles want 0", bad); else passed++;
    total++; if (trap_cause !== 2'b00 || instret !== 32'd0) $display("FAIL halt_state: got cause=%b instret=%0d want 00 0", trap_cause, instret); else passed++;
  endtask
  task automatic test_reset_mid();
    apply_reset();
    ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1; dec_reg_write = 1'b1; lsu_req_ready = 1'b1;
    release_reset();
    repeat (5) next_cycle();
    dec_mem_read = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    total++; if (instret !== 32'd1 || lsu_req_valid !== 1'b0 || ifu_req_valid !== 1'b0) $display("FAIL mid_pre: got instret=%0d lsu_valid=%b ifu_valid=%b want 1 0 0", instret, lsu_req_valid, ifu_req_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (instret !== 32'd0 || {ifu_req_valid, lsu_req_valid, rf_we, pc_we, retire, halt} !== 6'b0) $display("FAIL mid_async: got instret=%0d strobes=%b want 0 0", instret, {ifu_req_valid, lsu_req_valid, rf_we, pc_we, retire, halt}); else passed++;
    release_reset();
    @(negedge clk);
    total++; if (ifu_req_valid !== 1'b1 || lsu_req_valid !== 1'b0 || instret !== 32'd0) $display("FAIL mid_release: got ifu_valid=%b lsu_valid=%b instret=%0d want 1 0 0", ifu_req_valid, lsu_req_valid, instret); else passed++;
  endtask
  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_branch_jump();
    test_mem_timeout(1'b0);
    test_mem_timeout(1'b1);
    test_ifu_faults();
    test_ecall_ebreak();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
